// File: rtl/obstacle_pkg.sv
// ----------------------------------------------------------------------------
// obstacle_pkg: state encoding, LFSR taps and screen defaults. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package obstacle_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HIT  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_X_BITWIDTH     = 8;
  localparam int DEF_Y_BITWIDTH     = 9;
  localparam int DEF_SCREEN_WIDTH   = 240;
  localparam int DEF_SCREEN_HEIGHT  = 320;
  localparam int DEF_OBSTACLE_WIDTH = 50;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_controller_if.sv
// ----------------------------------------------------------------------------
// obstacle_controller_if: frame strobe, collision flag and obstacle outputs. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface obstacle_controller_if #(
  parameter int X_BITWIDTH = 8,
  parameter int Y_BITWIDTH = 9
);
  logic                  update;
  logic                  collision;
  logic [X_BITWIDTH-1:0] x;
  logic [Y_BITWIDTH-1:0] y;
  logic [7:0]            score;
  logic [1:0]            lives;
  logic                  hit;
  logic                  game_over;

  modport master (
    output update, collision,
    input  x, y, score, lives, hit, game_over
  );

  modport slave (
    input  update, collision,
    output x, y, score, lives, hit, game_over
  );
endinterface

`default_nettype wire

// File: rtl/obstacle_lfsr.sv
// ----------------------------------------------------------------------------
// obstacle_lfsr: 8-bit Fibonacci LFSR, advances when enabled. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module obstacle_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable_i,
  output logic [7:0] next_o
);

  logic [7:0] state_q;

  // Exposes the post-advance value so the respawn uses it in the same cycle.
  assign next_o = lfsr_step(state_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else if (enable_i) begin
      state_q <= next_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/obstacle_controller.sv
// ----------------------------------------------------------------------------
// obstacle_controller: frame-driven obstacle motion, score and lives FSM. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module obstacle_controller
  import obstacle_pkg::*;
#(
  parameter int         X_BITWIDTH     = DEF_X_BITWIDTH,
  parameter int         Y_BITWIDTH     = DEF_Y_BITWIDTH,
  parameter int         SCREEN_WIDTH   = DEF_SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
  parameter int         OBSTACLE_WIDTH = DEF_OBSTACLE_WIDTH,
  parameter int         SPEED          = 2,
  parameter int         LIVES          = 3,
  parameter int         HIT_FRAMES     = 30,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  obstacle_controller_if.slave  bus
);

  localparam int                    XRANGE  = SCREEN_WIDTH - OBSTACLE_WIDTH + 1;
  localparam logic [X_BITWIDTH-1:0] X_RESET = X_BITWIDTH'((SCREEN_WIDTH - OBSTACLE_WIDTH) / 2);
  localparam logic [Y_BITWIDTH:0]   Y_LIMIT = (Y_BITWIDTH + 1)'(SCREEN_HEIGHT);
  localparam logic [Y_BITWIDTH:0]   Y_STEP  = (Y_BITWIDTH + 1)'(SPEED);
  localparam logic [1:0]            LIVES_0 = 2'(LIVES);
  localparam logic [7:0]            HIT_LD  = 8'(HIT_FRAMES);

  logic [1:0]            state_q, state_d;
  logic [X_BITWIDTH-1:0] x_q, x_d;
  logic [Y_BITWIDTH-1:0] y_q, y_d;
  logic [7:0]            score_q, score_d;
  logic [1:0]            lives_q, lives_d;
  logic [7:0]            hit_cnt_q, hit_cnt_d;

  logic [7:0]            lfsr_next;
  logic [8:0]            rnd;
  logic [8:0]            col;
  logic [X_BITWIDTH-1:0] respawn_x;
  logic [Y_BITWIDTH:0]   ny;

  obstacle_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .enable_i (bus.update),
    .next_o   (lfsr_next)
  );

  // Single conditional subtract folds 0..255 into 0..XRANGE-1 given 2*XRANGE >= 256.
  assign rnd       = {1'b0, lfsr_next};
  assign col       = (rnd < 9'(XRANGE)) ? rnd : (rnd - 9'(XRANGE));
  assign respawn_x = X_BITWIDTH'(col);
  assign ny        = {1'b0, y_q} + Y_STEP;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    score_d   = score_q;
    lives_d   = lives_q;
    hit_cnt_d = hit_cnt_q;
    if (bus.update) begin
      case (state_q)
        ST_RUN: begin
          if (bus.collision) begin
            if (lives_q > 2'd1) begin
              lives_d   = lives_q - 2'd1;
              hit_cnt_d = HIT_LD;
              state_d   = ST_HIT;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end else if (ny >= Y_LIMIT) begin
            x_d = respawn_x;
            y_d = '0;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else begin
            y_d = ny[Y_BITWIDTH-1:0];
          end
        end
        ST_HIT: begin
          if (hit_cnt_q == 8'd1) begin
            x_d     = respawn_x;
            y_d     = '0;
            state_d = ST_RUN;
          end else begin
            hit_cnt_d = hit_cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      x_q       <= X_RESET;
      y_q       <= '0;
      score_q   <= '0;
      lives_q   <= LIVES_0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.hit       = (state_q == ST_HIT);
  assign bus.game_over = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_obstacle_controller.sv
// ----------------------------------------------------------------------------
// tb_obstacle_controller: scoreboard bench against a frame-level game model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_obstacle_controller;

  localparam int SW = 240;
  localparam int SH = 320;
  localparam int OW = 50;
  localparam int SPD = 2;
  localparam int NLIVES = 3;
  localparam int HITF = 30;

  typedef struct {
    int x;
    int y;
    int score;
    int lives;
    int hit;
    int over;
  } exp_t;

  logic clock;
  logic reset;

  obstacle_controller_if #(.X_BITWIDTH(8), .Y_BITWIDTH(9)) bus ();

  obstacle_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  // Reference model: game described in frames, not registers.
  int       m_x, m_y, m_score, m_lives, m_mode, m_left;
  bit [7:0] m_lfsr;

  function automatic void model_reset();
    m_x     = (SW - OW) / 2;
    m_y     = 0;
    m_score = 0;
    m_lives = NLIVES;
    m_mode  = 0;
    m_left  = 0;
    m_lfsr  = 8'hA5;
  endfunction

  function automatic void model_respawn();
    m_y = 0;
    m_x = int'(m_lfsr) % (SW - OW + 1);
  endfunction

  function automatic void model_step(input bit col);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (m_mode == 0) begin
      if (col) begin
        m_lives = m_lives - 1;
        if (m_lives > 0) begin
          m_mode = 1;
          m_left = HITF;
        end else begin
          m_mode = 2;
        end
      end else if (m_y + SPD >= SH) begin
        model_respawn();
        if (m_score < 255) m_score = m_score + 1;
      end else begin
        m_y = m_y + SPD;
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        model_respawn();
        m_mode = 0;
      end
    end
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.x     = m_x;
    e.y     = m_y;
    e.score = m_score;
    e.lives = m_lives;
    e.hit   = (m_mode == 1) ? 1 : 0;
    e.over  = (m_mode == 2) ? 1 : 0;
    return e;
  endfunction

  task automatic compare_exp(input string name, input exp_t e);
    vectors++;
    if (int'(bus.x) != e.x || int'(bus.y) != e.y || int'(bus.score) != e.score ||
        int'(bus.lives) != e.lives || int'(bus.hit) != e.hit || int'(bus.game_over) != e.over) begin
      miscompares++;
      $display("FAIL %s at %0t: got x=%0d y=%0d score=%0d lives=%0d hit=%0d over=%0d, want x=%0d y=%0d score=%0d lives=%0d hit=%0d over=%0d",
               name, $time, bus.x, bus.y, bus.score, bus.lives, bus.hit, bus.game_over,
               e.x, e.y, e.score, e.lives, e.hit, e.over);
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Monitor: every sampled strobe produces one observable output vector.
  bit upd_seen;
  always @(posedge clock) upd_seen <= bus.update && !reset;

  always @(negedge clock) begin
    if (upd_seen) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow at %0t: got output with no expectation, want none", $time);
      end else begin
        compare_exp("sb_vector", exp_q.pop_front());
      end
    end
  end

  task automatic tick_update(input bit col);
    bus.update    = 1'b1;
    bus.collision = col;
    model_step(col);
    exp_q.push_back(model_snapshot());
    @(posedge clock);
    #1;
    bus.update    = 1'b0;
    bus.collision = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    @(posedge clock);
    #1;
  endtask

  // Reset lands between edges; outputs are checked before any edge occurs.
  task automatic do_reset(input string name);
    #2;
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    #1;
    compare_exp(name, model_snapshot());
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    bus.update    = 1'b0;
    bus.collision = 1'b0;
    reset         = 1'b1;
    model_reset();
    #2;
    compare_exp("reset_state", model_snapshot());
    #21;
    reset = 1'b0;
    @(posedge clock);
    #1;

    repeat (5) tick_update(1'b0);
    drain();
    check_val("y_after5", int'(bus.y), 10);
    check_val("x_after5", int'(bus.x), 95);
    check_val("hit_after5", int'(bus.hit), 0);

    repeat (155) tick_update(1'b0);
    drain();
    check_val("y_after160", int'(bus.y), 0);
    check_val("score_after160", int'(bus.score), 1);
    check_val("x_in_range", (int'(bus.x) <= 190) ? 1 : 0, 1);

    repeat (10) tick_update(1'b0);
    tick_update(1'b1);
    drain();
    check_val("lives_after_hit", int'(bus.lives), 2);
    check_val("hit_flag", int'(bus.hit), 1);
    repeat (29) tick_update(1'($urandom_range(0, 1)));
    drain();
    check_val("y_held_in_hit", int'(bus.y), 20);
    tick_update(1'b1);
    drain();
    check_val("y_after_hit_exit", int'(bus.y), 0);

    repeat (159) tick_update(1'b0);
    drain();
    check_val("y_before_wrap", int'(bus.y), 318);
    tick_update(1'b1);
    drain();
    check_val("score_on_wrap_collision", int'(bus.score), 1);
    check_val("y_on_wrap_collision", int'(bus.y), 318);
    repeat (HITF) tick_update(1'b0);

    repeat (7) tick_update(1'b0);
    tick_update(1'b1);
    drain();
    check_val("game_over", int'(bus.game_over), 1);
    check_val("lives_zero", int'(bus.lives), 0);
    repeat (10) tick_update(1'($urandom_range(0, 1)));
    drain();

    do_reset("sync_reset");
    repeat (3) tick_update(1'b0);
    tick_update(1'b1);
    repeat (5) tick_update(1'b0);
    drain();
    check_val("in_hit_before_reset", int'(bus.hit), 1);
    do_reset("async_reset_mid_hit");

    repeat (400) begin
      tick_update(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
      repeat ($urandom_range(0, 2)) drain();
    end
    drain();

    do_reset("reset_before_sat");
    repeat (300 * 160) tick_update(1'b0);
    drain();
    check_val("score_saturated", int'(bus.score), 255);

    drain();
    check_val("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
